// File: rtl/memb_load_ctrl.sv
// memB load sequencer: fetches DIM rows of B from SRAM, feeds them to the
// skew FIFOs, then flushes with zero beats. A 1-entry skid absorbs stalls.
module memb_load_ctrl #(
  parameter int BITS_AB = 8,
  parameter int DIM     = 8,
  parameter int ADDR_W  = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic                   stall,
  output logic                   busy,
  output logic                   done,
  output logic                   mem_rd_en,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [DIM*BITS_AB-1:0] mem_rdata,
  output logic                   b_en,
  output logic [DIM*BITS_AB-1:0] b_vec
);

  localparam int FLUSH = 2*DIM-1;
  localparam int W     = DIM*BITS_AB;
  localparam int CW    = $clog2(DIM+1);
  localparam int ZW    = $clog2(FLUSH+1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]     row_cnt_q, row_cnt_d;
  logic [ZW-1:0]     z_cnt_q, z_cnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic              skid_v_q, skid_v_d;
  logic [W-1:0]      skid_q, skid_d;
  logic [W-1:0]      b_vec_q, b_vec_d;

  logic              avail;
  logic              skid_free;
  logic [W-1:0]      row;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    rd_cnt_d  = rd_cnt_q;
    row_cnt_d = row_cnt_q;
    z_cnt_d   = z_cnt_q;
    skid_v_d  = skid_v_q;
    skid_d    = skid_q;
    busy      = (state_q != S_IDLE);
    done      = 1'b0;
    mem_rd_en = 1'b0;
    mem_addr  = base_q + ADDR_W'(rd_cnt_q);
    b_en      = 1'b0;
    b_vec     = b_vec_q;
    avail     = skid_v_q | rd_pend_q;
    row       = skid_v_q ? skid_q : mem_rdata;
    // a full skid counts as free when it is being drained this cycle
    skid_free = !skid_v_q || !stall;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_FETCH;
          base_d    = base_addr;
          rd_cnt_d  = '0;
          row_cnt_d = '0;
          z_cnt_d   = '0;
          skid_v_d  = 1'b0;
        end
      end
      S_FETCH: begin
        mem_rd_en = !stall && (rd_cnt_q < CW'(DIM)) && skid_free;
        if (mem_rd_en) rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_pend_q && (stall || skid_v_q)) begin
          skid_d   = mem_rdata;
          skid_v_d = 1'b1;
        end else if (!stall) begin
          skid_v_d = 1'b0;
        end
        if (!stall && avail) begin
          b_en      = 1'b1;
          b_vec     = row;
          row_cnt_d = row_cnt_q + 1'b1;
          if (row_cnt_q == CW'(DIM-1)) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (!stall) begin
          b_en    = 1'b1;
          b_vec   = '0;
          z_cnt_d = z_cnt_q + 1'b1;
          if (z_cnt_q == ZW'(FLUSH-1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    b_vec_d   = b_vec;
    rd_pend_d = mem_rd_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      rd_cnt_q  <= '0;
      row_cnt_q <= '0;
      z_cnt_q   <= '0;
      rd_pend_q <= 1'b0;
      skid_v_q  <= 1'b0;
      skid_q    <= '0;
      b_vec_q   <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      rd_cnt_q  <= rd_cnt_d;
      row_cnt_q <= row_cnt_d;
      z_cnt_q   <= z_cnt_d;
      rd_pend_q <= rd_pend_d;
      skid_v_q  <= skid_v_d;
      skid_q    <= skid_d;
      b_vec_q   <= b_vec_d;
    end
  end

endmodule

// File: tb/tb_memb_load_ctrl.sv
// Bench for memb_load_ctrl: SRAM model, beat/address scoreboard,
// directed timing checks and a randomized stall soak.
module tb_memb_load_ctrl;

  localparam int DIM   = 8;
  localparam int BITS  = 8;
  localparam int AW    = 10;
  localparam int W     = DIM*BITS;
  localparam int BEATS = 3*DIM-1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          stall;
  logic          busy, done, mem_rd_en, b_en;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_rdata = '0;
  logic [W-1:0]  b_vec;

  memb_load_ctrl #(.BITS_AB(BITS), .DIM(DIM), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .stall(stall), .busy(busy), .done(done), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .b_en(b_en), .b_vec(b_vec)
  );

  always #5 clk = ~clk;

  logic [W-1:0] sram [1024];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= sram[mem_addr];

  int tests = 0;
  int fails = 0;

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model state
  logic [W-1:0]  exp_q[$];
  logic [AW-1:0] addr_q[$];
  bit            active, done_next, pend_done, chk_en;
  logic [W-1:0]  last_vec = '0;
  int            beat_cnt, done_seen, gcyc, acc_cyc, done_rel;
  int            rd_cyc_log[$], beat_cyc_log[$];
  logic [AW-1:0] rd_addr_log[$];
  logic [W-1:0]  beat_val_log[$];

  always @(negedge clk) begin
    logic [W-1:0]  ev;
    logic [AW-1:0] ea;
    bit            acc;
    gcyc++;
    if (chk_en) begin
      chk("busy", busy, active);
      chk("done", done, done_next);
      if (done) begin
        chk("beats_per_load", beat_cnt, BEATS);
        done_seen++;
        done_rel = gcyc - acc_cyc;
      end
      if (b_en) begin
        chk("b_en_under_stall", stall, 0);
        if (exp_q.size() == 0) begin
          chk("extra_beat", b_en, 0);
        end else begin
          ev = exp_q.pop_front();
          chk("b_vec", b_vec, ev);
          last_vec = ev;
          beat_cnt++;
          beat_cyc_log.push_back(gcyc - acc_cyc);
          beat_val_log.push_back(b_vec);
          if (exp_q.size() == 0) pend_done = 1;
        end
      end else begin
        chk("b_vec_hold", b_vec, last_vec);
      end
      if (mem_rd_en) begin
        chk("rd_under_stall", stall, 0);
        if (addr_q.size() == 0) begin
          chk("extra_read", mem_rd_en, 0);
        end else begin
          ea = addr_q.pop_front();
          chk("mem_addr", mem_addr, ea);
          rd_cyc_log.push_back(gcyc - acc_cyc);
          rd_addr_log.push_back(mem_addr);
        end
      end
      acc = start && !active;
      if (rst) begin
        exp_q.delete();
        addr_q.delete();
        active = 0;
        done_next = 0;
        pend_done = 0;
        last_vec = '0;
      end else begin
        if (done_next) begin
          active = 0;
          done_next = 0;
        end
        if (pend_done) begin
          done_next = 1;
          pend_done = 0;
        end
        if (acc) begin
          active = 1;
          beat_cnt = 0;
          acc_cyc = gcyc;
          rd_cyc_log.delete();
          beat_cyc_log.delete();
          rd_addr_log.delete();
          beat_val_log.delete();
          for (int k = 0; k < DIM; k++) begin
            logic [AW-1:0] a;
            a = base_addr + AW'(k);
            addr_q.push_back(a);
            exp_q.push_back(sram[a]);
          end
          for (int k = 0; k < 2*DIM-1; k++) exp_q.push_back('0);
        end
      end
    end
  end

  function automatic logic [W-1:0] seq_row(int k);
    logic [W-1:0] v;
    for (int i = 0; i < DIM; i++) v[i*BITS +: BITS] = BITS'(8*k + i);
    return v;
  endfunction

  task automatic run_load(input logic [AW-1:0] base, input int mode,
                          input bit inj_start, input bit inj_rst);
    int d0;
    d0 = done_seen;
    base_addr = base;
    start = 1;
    stall = 0;
    @(posedge clk); #1;
    start = 0;
    for (int c = 1; c < 300; c++) begin
      if (inj_rst && c == 12) break;
      stall = (mode == 1) ? (c >= 4 && c <= 6) :
              (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      start = inj_start && (c == 5);
      rst   = inj_rst && (c == 6);
      @(posedge clk); #1;
      if (done_seen != d0) break;
    end
    start = 0;
    stall = 0;
    rst   = 0;
    chk("load_completes", done_seen - d0, inj_rst ? 0 : 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [AW-1:0] t3 [8];
    rst = 1;
    start = 0;
    stall = 0;
    base_addr = '0;
    for (int a = 0; a < 1024; a++) sram[a] = {$urandom, $urandom};
    for (int k = 0; k < DIM; k++) sram[10'h010 + k] = seq_row(k);

    @(posedge clk); #1;
    chk_en = 1;
    @(negedge clk);
    chk("rst_b_en", b_en, 0);
    chk("rst_mem_rd_en", mem_rd_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_b_vec", b_vec, 0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    run_load(10'h010, 0, 0, 0);
    chk("t1_done_cycle", done_rel, 25);
    chk("t1_beat_total", beat_cyc_log.size(), 23);
    for (int k = 0; k < DIM; k++) begin
      chk("t1_rd_cycle", rd_cyc_log[k], k + 1);
      chk("t1_rd_addr", rd_addr_log[k], 10'h010 + k);
      chk("t1_row_cycle", beat_cyc_log[k], k + 2);
      chk("t1_row_val", beat_val_log[k], seq_row(k));
    end
    chk("t1_first_zero", beat_cyc_log[8], 10);
    chk("t1_last_zero", beat_cyc_log[22], 24);

    run_load(10'h010, 1, 0, 0);
    chk("t2_done_cycle", done_rel, 28);
    chk("t2_row1_cycle", beat_cyc_log[1], 3);
    chk("t2_skid_cycle", beat_cyc_log[2], 7);
    chk("t2_skid_val", beat_val_log[2], seq_row(2));
    chk("t2_row3_cycle", beat_cyc_log[3], 8);

    run_load(10'h3FC, 0, 0, 0);
    t3 = '{10'h3FC, 10'h3FD, 10'h3FE, 10'h3FF,
           10'h000, 10'h001, 10'h002, 10'h003};
    for (int k = 0; k < DIM; k++) chk("t3_wrap_addr", rd_addr_log[k], t3[k]);

    run_load(10'h123, 0, 1, 0);
    chk("t4_beat_total", beat_cyc_log.size(), 23);

    run_load(10'h200, 0, 0, 1);
    chk("t5_idle_busy", busy, 0);
    run_load(10'h010, 0, 0, 0);
    chk("t5_clean_done", done_rel, 25);

    for (int n = 0; n < 200; n++) run_load(AW'($urandom), 2, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
